// File: rtl/parity_pkg.sv
// parity_pkg: shared parity mode type and expected-parity helper
package parity_pkg;
  typedef enum logic {ODD = 1'b0, EVEN = 1'b1} parity_mode_e;
  function automatic logic parity_bit(input logic [7:0] d, input parity_mode_e m);
    return (m == EVEN) ? ^d : ~^d;
  endfunction
endpackage

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter with half-bit and full-bit ticks
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            restart,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
  output logic                            half_tick,
  output logic                            full_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  assign half_tick = cnt == W'(CLKS_PER_BIT / 2 - 1);
  assign full_tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= (restart || full_tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8P1 UART receiver with valid/ready output and error flags
module uart_rx import uart_pkg::*, parity_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_i,
  input  logic         parity_en_i,
  input  parity_mode_e parity_mode_i,
  output logic [7:0]   data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         parity_err_o,
  output logic         frame_err_o,
  output logic         overrun_o
);
  logic [SYNC_STAGES-1:0]          sync;
  logic                            rx_s, rx_prev, fall, restart, done;
  logic                            half_tick, full_tick, unused_tick;
  logic [$clog2(CLKS_PER_BIT)-1:0] tick_cnt;
  logic [2:0]                      bit_cnt;
  logic [7:0]                      shreg;
  logic                            par_en, par_err;
  parity_mode_e                    par_mode;
  rx_state_e                       state, state_n;
  assign rx_s        = sync[SYNC_STAGES-1];
  assign fall        = rx_prev && !rx_s;
  assign restart     = state == IDLE && fall;
  assign done        = state == STOP && half_tick;
  assign unused_tick = ^{tick_cnt, full_tick};
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk), .rst(rst), .restart(restart),
    .cnt(tick_cnt), .half_tick(half_tick), .full_tick(full_tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = fall ? START : IDLE;
      START:     state_n = half_tick ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_n = (half_tick && bit_cnt == 3'd7) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:    state_n = half_tick ? STOP : PARITY;
      STOP:      state_n = half_tick ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync         <= '1;
      rx_prev      <= 1'b1;
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_en       <= 1'b0;
      par_mode     <= ODD;
      par_err      <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      sync      <= SYNC_STAGES'({sync, rx_i});
      rx_prev   <= rx_s;
      state     <= state_n;
      overrun_o <= done && valid_o && !ready_i;
      if (restart) begin
        par_en   <= parity_en_i;
        par_mode <= parity_mode_i;
        par_err  <= 1'b0;
        bit_cnt  <= '0;
      end
      if (state == DATA && half_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && half_tick) par_err <= rx_s != parity_bit(shreg, par_mode);
      // a completing byte may reuse the slot being handed off this same cycle
      if (done && (!valid_o || ready_i)) begin
        data_o       <= shreg;
        parity_err_o <= par_err;
        frame_err_o  <= !rx_s;
        valid_o      <= 1'b1;
      end else if (ready_i) valid_o <= 1'b0;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the flop count of the rx_i synchronizer.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line; idle high; 8N1 or 8P1 framing, LSB first.
REQ-006 SHALL have port parity_en_i  input  1  1 = a parity bit follows the data bits.
REQ-007 SHALL have port parity_mode_i  input  1  parity_pkg::parity_mode_e; ODD=0, EVEN=1.
REQ-008 SHALL have port data_o  output  8  received byte.
REQ-009 SHALL have port valid_o  output  1  data_o and the error flags are valid.
REQ-010 SHALL have port ready_i  input  1  consumer accepts the byte when valid_o && ready_i.
REQ-011 SHALL have port parity_err_o  output  1  parity mismatch for the byte on data_o.
REQ-012 SHALL have port frame_err_o  output  1  stop bit sampled low for the byte on data_o.
REQ-013 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-014 SHALL synchronize rx_i through SYNC_STAGES flops, each reset to 1; all logic below uses the synchronized value rx_s.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 IDLE SHALL move to START on an rx_s 1->0 transition; parity_en_i and parity_mode_i SHALL be latched at this cycle and held for the frame.
REQ-017 START SHALL sample rx_s after CLKS_PER_BIT/2 cycles; a low sample moves to DATA; a high sample is a glitch and returns to IDLE with no output.
REQ-018 DATA SHALL sample rx_s every CLKS_PER_BIT cycles from the start mid-point, 8 samples, shifting in LSB first.
REQ-019 After the 8th data sample, DATA SHALL move to PARITY when parity is latched enabled, else to STOP.
REQ-020 PARITY SHALL take one sample; a mismatch SHALL set parity_err, where the expected bit is ~^data for ODD and ^data for EVEN.
REQ-021 STOP SHALL take one sample; a low sample SHALL set frame_err and the next state SHALL be WAIT_HIGH, else IDLE.
REQ-022 WAIT_HIGH SHALL return to IDLE only once rx_s is high, so no false start is taken on a held-low line.
REQ-023 The byte and its flags SHALL be presented on the cycle after the stop sample: valid_o rises one cycle after the stop mid-bit.
REQ-024 A byte with frame_err or parity_err SHALL still be delivered with valid_o=1.
REQ-025 valid_o SHALL stay high, and data_o and the error flags SHALL stay stable, until valid_o && ready_i.
REQ-026 A byte completing while valid_o=1 && !ready_i SHALL be dropped, overrun_o SHALL pulse for 1 cycle, and the held byte SHALL be unchanged.
REQ-027 A byte completing in the same cycle as a valid_o && ready_i handshake SHALL be loaded, valid_o SHALL stay 1, and no overrun SHALL occur.
REQ-028 The bit-timing counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0, and restart at 0 on every start detection.

Reset
REQ-029 On rst: state=IDLE, counters=0, shift register=0, synchronizer=1, data_o=0x00, and valid_o, parity_err_o, frame_err_o and overrun_o = 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no partial byte delivered; reception SHALL resume on the next falling edge after release.

Structure
REQ-031 The state enum SHALL reside in a shared uart_pkg; parity_mode_e and the parity computation SHALL be taken from parity_pkg, not redefined.
REQ-032 Bit timing SHALL be a sub-module uart_baud_tick (counter, half-bit and full-bit tick outputs, restart input), reusable by a transmitter.

Verification
REQ-033 SHALL cover: EVEN, 0x55, parity bit 0, ready_i=1 -> data_o=0x55, valid_o for 1 cycle, no error flags.
REQ-034 SHALL cover: ODD, 0xA7 (5 ones), parity bit 1 -> data_o=0xA7, parity_err_o=1, frame_err_o=0.
REQ-035 SHALL cover: rx_i low for 4 cycles (CLKS_PER_BIT=16) -> no valid_o; a following 0x3C frame received correctly.
REQ-036 SHALL cover: parity disabled, 0x81, stop bit low held 3 bit-times -> 0x81 with frame_err_o=1; no second byte until the line goes high and falls again.
REQ-037 SHALL cover: ready_i=0, frames 0x11 then 0x22 -> data_o stays 0x11, overrun_o pulses once; after ready_i=1, valid_o drops.
REQ-038 SHALL cover: rst pulsed at data bit 4 of 0xF0 -> all outputs 0, no byte delivered; the next 0x0F frame is received correctly.
